// File: rtl/axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_pkt_arbiter
// Brief    : Round-robin, packet-granular N:1 AXI-Stream arbiter with tid tag.
// Revision : 1.0 - initial release
// ============================================================================
module axis_pkt_arbiter #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = $clog2(NUM_PORTS)
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_PORTS-1:0]            s_axis_tlast,
    input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
    output logic [NUM_PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]           m_axis_tdata,
    output logic                            m_axis_tlast,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic [ID_WIDTH-1:0]             m_axis_tid
);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_BUSY = 1'b1;
    localparam int         c_SCAN_W = ID_WIDTH + 1;

    logic [0:0]            r_state;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   r_last_grant;

    logic [DATA_WIDTH-1:0] w_port_data [NUM_PORTS];
    logic [ID_WIDTH-1:0]   w_next;
    logic [c_SCAN_W-1:0]   w_cand;
    logic                  w_found;

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_unpack
            assign w_port_data[i] = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // Scan upward from last_grant+1; the extra bit keeps the sum exact before wrapping.
    always_comb begin
        w_next  = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            w_cand = {1'b0, r_last_grant} + c_SCAN_W'(k);
            if (w_cand >= c_SCAN_W'(NUM_PORTS)) begin
                w_cand = w_cand - c_SCAN_W'(NUM_PORTS);
            end
            if (!w_found && s_axis_tvalid[w_cand[ID_WIDTH-1:0]]) begin
                w_found = 1'b1;
                w_next  = w_cand[ID_WIDTH-1:0];
            end
        end
    end

    assign m_axis_tdata  = w_port_data[r_grant];
    assign m_axis_tlast  = s_axis_tlast[r_grant];
    assign m_axis_tvalid = (r_state == c_S_BUSY) && s_axis_tvalid[r_grant];
    assign m_axis_tid    = r_grant;

    always_comb begin
        s_axis_tready = '0;
        if (r_state == c_S_BUSY) begin
            s_axis_tready[r_grant] = m_axis_tready;
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            r_state      <= c_S_IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_WIDTH'(NUM_PORTS - 1);
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_next;
                        r_state <= c_S_BUSY;
                    end
                end
                c_S_BUSY: begin
                    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                        r_last_grant <= r_grant;
                        r_state      <= c_S_IDLE;
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_pkt_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axis_pkt_arbiter
// Brief    : Directed self-checking bench for axis_pkt_arbiter (4 x 32-bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_axis_pkt_arbiter;

    localparam int c_NP = 4;
    localparam int c_DW = 32;

    logic                 ACLK = 1'b0;
    logic                 ARESETn;
    logic [c_NP*c_DW-1:0] r_s_tdata;
    logic [c_NP-1:0]      r_s_tlast;
    logic [c_NP-1:0]      r_s_tvalid;
    logic [c_NP-1:0]      w_s_tready;
    logic [c_DW-1:0]      w_m_tdata;
    logic                 w_m_tlast;
    logic                 w_m_tvalid;
    logic                 r_m_tready;
    logic [1:0]           w_m_tid;

    int n_vec = 0;
    int n_err = 0;

    always #5 ACLK = ~ACLK;

    axis_pkt_arbiter #(
        .NUM_PORTS (c_NP),
        .DATA_WIDTH(c_DW)
    ) u_dut (
        .ACLK         (ACLK),
        .ARESETn      (ARESETn),
        .s_axis_tdata (r_s_tdata),
        .s_axis_tlast (r_s_tlast),
        .s_axis_tvalid(r_s_tvalid),
        .s_axis_tready(w_s_tready),
        .m_axis_tdata (w_m_tdata),
        .m_axis_tlast (w_m_tlast),
        .m_axis_tvalid(w_m_tvalid),
        .m_axis_tready(r_m_tready),
        .m_axis_tid   (w_m_tid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic l, input logic [31:0] d);
        r_s_tvalid[p]          = v;
        r_s_tlast[p]           = l;
        r_s_tdata[p*c_DW +: c_DW] = d;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] d, input logic l,
                            input logic [1:0] id, input logic [3:0] rdy);
        chk({tag, ".valid"}, 64'(w_m_tvalid), 64'd1);
        chk({tag, ".data"},  64'(w_m_tdata),  64'(d));
        chk({tag, ".last"},  64'(w_m_tlast),  64'(l));
        chk({tag, ".tid"},   64'(w_m_tid),    64'(id));
        chk({tag, ".ready"}, 64'(w_s_tready), 64'(rdy));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 64'(w_m_tvalid), 64'd0);
        chk({tag, ".ready"}, 64'(w_s_tready), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bi;
        logic [1:0] exp_e [7];
        exp_e = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2};

        ARESETn    = 1'b0;
        r_s_tdata  = '0;
        r_s_tlast  = '0;
        r_s_tvalid = '0;
        r_m_tready = 1'b1;

        // Reset: idle outputs, data/last follow port 0
        tick; tick;
        set_port(0, 1'b0, 1'b1, 32'hA5A5_0000);
        #1;
        chk_idle("rst");
        chk("rst.tid",  64'(w_m_tid),   64'd0);
        chk("rst.data", 64'(w_m_tdata), 64'hA5A5_0000);
        chk("rst.last", 64'(w_m_tlast), 64'd1);

        // Ports 1 and 3 each send two beats
        ARESETn = 1'b1;
        set_port(0, 1'b0, 1'b0, 32'h0);
        set_port(1, 1'b1, 1'b0, 32'h0000_00A0);
        set_port(3, 1'b1, 1'b0, 32'h0000_00B0);
        #1; chk_idle("t1.arb1");
        tick; #1; chk_beat("t1.A0", 32'hA0, 1'b0, 2'd1, 4'b0010);
        tick; set_port(1, 1'b1, 1'b1, 32'h0000_00A1);
        #1; chk_beat("t1.A1", 32'hA1, 1'b1, 2'd1, 4'b0010);
        tick; set_port(1, 1'b0, 1'b0, 32'h0);
        #1; chk_idle("t1.arb3");
        tick; #1; chk_beat("t1.B0", 32'hB0, 1'b0, 2'd3, 4'b1000);
        tick; set_port(3, 1'b1, 1'b1, 32'h0000_00B1);
        #1; chk_beat("t1.B1", 32'hB1, 1'b1, 2'd3, 4'b1000);
        tick; set_port(3, 1'b0, 1'b0, 32'h0);
        #1; chk_idle("t1.end");

        // All ports request single-beat packets continuously
        for (int p = 0; p < c_NP; p++) set_port(p, 1'b1, 1'b1, 32'h100 + 32'(p));
        for (int i = 0; i < 12; i++) begin
            tick; #1;
            chk_beat($sformatf("t2.g%0d", i), 32'h100 + 32'(i % 4), 1'b1,
                     2'(i % 4), 4'b0001 << (i % 4));
            tick; #1;
            chk_idle($sformatf("t2.b%0d", i));
        end
        r_s_tvalid = '0;

        // Port 2 four-beat packet; port 0 requests after the first beat
        set_port(2, 1'b1, 1'b0, 32'h0000_00C0);
        #1; chk_idle("t3.arb");
        tick; #1; chk_beat("t3.C0", 32'hC0, 1'b0, 2'd2, 4'b0100);
        tick; set_port(2, 1'b1, 1'b0, 32'h0000_00C1);
        set_port(0, 1'b1, 1'b1, 32'h0000_00D0);
        #1; chk_beat("t3.C1", 32'hC1, 1'b0, 2'd2, 4'b0100);
        tick; set_port(2, 1'b1, 1'b0, 32'h0000_00C2);
        #1; chk_beat("t3.C2", 32'hC2, 1'b0, 2'd2, 4'b0100);
        tick; set_port(2, 1'b1, 1'b1, 32'h0000_00C3);
        #1; chk_beat("t3.C3", 32'hC3, 1'b1, 2'd2, 4'b0100);
        tick; set_port(2, 1'b0, 1'b0, 32'h0);
        #1; chk_idle("t3.arb0");
        tick; #1; chk_beat("t3.D0", 32'hD0, 1'b1, 2'd0, 4'b0001);
        tick; set_port(0, 1'b0, 1'b0, 32'h0);
        #1; chk_idle("t3.end");

        // Backpressure on a three-beat packet from port 3
        bi = 0;
        set_port(3, 1'b1, 1'b0, 32'h0000_00E0);
        #1; chk_idle("t4.arb");
        tick;
        for (int k = 0; k < 7; k++) begin
            r_m_tready = (k % 3 == 0);
            set_port(3, 1'b1, bi == 2, 32'h0000_00E0 + 32'(bi));
            #1;
            chk_beat($sformatf("t4.k%0d", k), 32'h0000_00E0 + 32'(exp_e[k]),
                     exp_e[k] == 2'd2, 2'd3, {r_m_tready, 3'b000});
            tick;
            if (r_m_tready) bi++;
        end
        set_port(3, 1'b0, 1'b0, 32'h0);
        r_m_tready = 1'b1;
        #1; chk_idle("t4.end");

        // Granted port 0 stalls for three cycles while port 1 waits
        set_port(0, 1'b1, 1'b0, 32'h0000_00F0);
        #1; chk_idle("t5.arb");
        tick; #1; chk_beat("t5.F0", 32'hF0, 1'b0, 2'd0, 4'b0001);
        tick; set_port(0, 1'b0, 1'b0, 32'h0);
        set_port(1, 1'b1, 1'b1, 32'h0000_0060);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("t5.stall%0d.valid", k), 64'(w_m_tvalid), 64'd0);
            chk($sformatf("t5.stall%0d.tid", k),   64'(w_m_tid),    64'd0);
            chk($sformatf("t5.stall%0d.ready", k), 64'(w_s_tready), 64'b0001);
            tick;
        end
        set_port(0, 1'b1, 1'b1, 32'h0000_00F1);
        #1; chk_beat("t5.F1", 32'hF1, 1'b1, 2'd0, 4'b0001);
        tick; set_port(0, 1'b0, 1'b0, 32'h0);
        #1; chk_idle("t5.arb1");
        tick; #1; chk_beat("t5.G0", 32'h60, 1'b1, 2'd1, 4'b0010);
        tick; set_port(1, 1'b0, 1'b0, 32'h0);
        #1; chk_idle("t5.end");

        // Reset in the middle of a port-1 packet
        set_port(1, 1'b1, 1'b0, 32'h0000_0070);
        #1; chk_idle("t6.arb");
        tick; #1; chk_beat("t6.H0", 32'h70, 1'b0, 2'd1, 4'b0010);
        tick; set_port(1, 1'b1, 1'b0, 32'h0000_0071);
        ARESETn = 1'b0;
        #1; chk_beat("t6.H1", 32'h71, 1'b0, 2'd1, 4'b0010);
        tick; ARESETn = 1'b1;
        set_port(1, 1'b1, 1'b1, 32'h0000_0080);
        set_port(2, 1'b1, 1'b1, 32'h0000_0090);
        #1; chk_idle("t6.rst");
        chk("t6.rst.tid", 64'(w_m_tid), 64'd0);
        tick; #1; chk_beat("t6.J0", 32'h80, 1'b1, 2'd1, 4'b0010);
        tick; set_port(1, 1'b0, 1'b0, 32'h0);
        #1; chk_idle("t6.arb2");
        tick; #1; chk_beat("t6.K0", 32'h90, 1'b1, 2'd2, 4'b0100);
        tick; set_port(2, 1'b0, 1'b0, 32'h0);
        #1; chk_idle("t6.end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
